// File: rtl/sint_delta_decoder_pkg.sv
// Shared constants, signed range helpers and output-register state type
// for the SInt delta decoder family.
package sint_delta_pkg;

  localparam int DEFAULT_WIDTH = 7;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int smax(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int smin(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/sint_delta_decoder_add_ovf.sv
// Combinational WIDTH-bit signed add with overflow flag and optional clamp
// to the signed range.
module sint_add_ovf #(
  parameter int WIDTH    = 7,
  parameter bit SATURATE = 1'b0
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] sum;

  assign sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign ovf = sum[WIDTH] ^ sum[WIDTH-1];

  // The extra MSB carries the true sign of the sum, so it picks the clamp rail.
  always_comb begin
    result = sum[WIDTH-1:0];
    if (SATURATE && ovf) begin
      result = sum[WIDTH] ? MIN_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/sint_delta_decoder.sv
// Rebuilds absolute signed samples from a delta stream; one-deep registered
// output with pass-through ready and keyframe resynchronisation.
module sint_delta_decoder
  import sint_delta_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit SATURATE = 1'b0,
  parameter int INIT     = 0,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESET,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic signed [WIDTH-1:0] in_delta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    overflow,
  output logic [CNT_W-1:0]        sample_count
);

  localparam logic signed [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  out_state_e              state;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] add_result;
  logic                    add_ovf;
  logic                    accept;

  sint_add_ovf #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a      (acc),
    .b      (in_delta),
    .result (add_result),
    .ovf    (add_ovf)
  );

  assign out_valid = (state == FULL);
  assign in_ready  = !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state        <= EMPTY;
      acc          <= INIT_V;
      out_data     <= INIT_V;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else if (clear) begin
      // out_data is deliberately left alone so a consumer can still inspect it
      state        <= EMPTY;
      acc          <= INIT_V;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else if (accept) begin
      state        <= FULL;
      acc          <= in_first ? in_delta : add_result;
      out_data     <= in_first ? in_delta : add_result;
      overflow     <= overflow | (!in_first && add_ovf);
      sample_count <= sample_count + 1'b1;
    end else if (out_valid && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_sint_delta_decoder.sv
// Self-checking bench: wrap and saturate decoders driven in lockstep against
// an integer-arithmetic reference model.
module tb_sint_delta_decoder;

  logic clk;
  logic rst;
  logic clear;
  logic in_valid;
  logic in_first;
  logic signed [6:0] in_delta;
  logic out_ready;

  logic rdy_w, vld_w, ovf_w;
  logic signed [6:0] data_w;
  logic [15:0] cnt_w;
  logic rdy_s, vld_s, ovf_s;
  logic signed [6:0] data_s;
  logic [15:0] cnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  int m_acc_w, m_acc_s, m_data_w, m_data_s, m_cnt;
  bit m_valid, m_ovf_w, m_ovf_s;

  sint_delta_decoder #(.WIDTH(7), .SATURATE(1'b0), .INIT(0), .CNT_W(16)) dut_w (
    .CLK(clk), .ASYNCRESET(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy_w), .in_first(in_first), .in_delta(in_delta),
    .out_valid(vld_w), .out_ready(out_ready), .out_data(data_w),
    .overflow(ovf_w), .sample_count(cnt_w)
  );

  sint_delta_decoder #(.WIDTH(7), .SATURATE(1'b1), .INIT(0), .CNT_W(16)) dut_s (
    .CLK(clk), .ASYNCRESET(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy_s), .in_first(in_first), .in_delta(in_delta),
    .out_valid(vld_s), .out_ready(out_ready), .out_data(data_s),
    .overflow(ovf_s), .sample_count(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int wrap7(input int s);
    int r;
    r = (s + 64) % 128;
    if (r < 0) r += 128;
    return r - 64;
  endfunction

  function automatic int clamp7(input int s);
    if (s > 63) return 63;
    if (s < -64) return -64;
    return s;
  endfunction

  function automatic bit out_of_range(input int s);
    return (s > 63) || (s < -64);
  endfunction

  task automatic model_reset();
    m_acc_w = 0; m_acc_s = 0; m_data_w = 0; m_data_s = 0;
    m_cnt = 0; m_valid = 0; m_ovf_w = 0; m_ovf_s = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_vld_w"}, vld_w, m_valid);
    chk({tag, "_vld_s"}, vld_s, m_valid);
    chk({tag, "_data_w"}, data_w, m_data_w);
    chk({tag, "_data_s"}, data_s, m_data_s);
    chk({tag, "_ovf_w"}, ovf_w, m_ovf_w);
    chk({tag, "_ovf_s"}, ovf_s, m_ovf_s);
    chk({tag, "_cnt_w"}, cnt_w, m_cnt);
    chk({tag, "_cnt_s"}, cnt_s, m_cnt);
  endtask

  // One cycle: drive at the falling edge, check ready, predict, check after the rising edge.
  task automatic step(input bit v, input bit f, input int d, input bit ordy, input bit clr,
                      input string tag);
    bit exp_rdy;
    int s_w, s_s;
    in_valid = v; in_first = f; in_delta = 7'(d); out_ready = ordy; clear = clr;
    #1;
    exp_rdy = !clr && (!m_valid || ordy);
    chk({tag, "_rdy_w"}, rdy_w, exp_rdy);
    chk({tag, "_rdy_s"}, rdy_s, exp_rdy);
    if (clr) begin
      m_acc_w = 0; m_acc_s = 0; m_valid = 0; m_ovf_w = 0; m_ovf_s = 0; m_cnt = 0;
    end else if (v && exp_rdy) begin
      if (f) begin
        m_acc_w = d; m_acc_s = d;
      end else begin
        s_w = m_acc_w + d;
        s_s = m_acc_s + d;
        if (out_of_range(s_w)) m_ovf_w = 1;
        if (out_of_range(s_s)) m_ovf_s = 1;
        m_acc_w = wrap7(s_w);
        m_acc_s = clamp7(s_s);
      end
      m_data_w = m_acc_w; m_data_s = m_acc_s;
      m_valid = 1;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; clear = 0; in_valid = 0; in_first = 0; in_delta = '0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic accumulation
    step(1, 1, 5, 1, 0, "basic0");
    chk("basic_first", data_w, 5);
    step(1, 0, -3, 1, 0, "basic1");
    chk("basic_second", data_w, 2);
    step(1, 0, 10, 1, 0, "basic2");
    chk("basic_third", data_w, 12);
    chk("basic_cnt", cnt_w, 3);
    step(0, 0, 0, 1, 0, "drain0");

    // positive overflow, keyframe, negative overflow
    step(1, 1, 60, 1, 0, "ovf0");
    step(1, 0, 10, 1, 0, "ovf1");
    chk("wrap_pos", data_w, -58);
    chk("sat_pos", data_s, 63);
    chk("wrap_ovf", ovf_w, 1);
    step(1, 1, -60, 1, 0, "ovf2");
    step(1, 0, -10, 1, 0, "ovf3");
    chk("wrap_neg", data_w, 58);
    chk("sat_neg", data_s, -64);
    chk("wrap_ovf_sticky", ovf_w, 1);

    // backpressure
    step(1, 1, 20, 1, 0, "bp0");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, "bp_stall");
    chk("bp_hold", data_w, 20);
    step(1, 0, 1, 1, 0, "bp_release");
    chk("bp_next", data_w, 21);

    // clear with in_valid high
    step(1, 1, 30, 1, 0, "clr0");
    step(1, 0, 5, 1, 1, "clr1");
    chk("clr_cnt", cnt_w, 0);
    chk("clr_vld", vld_w, 0);
    step(1, 0, 4, 1, 0, "clr2");
    chk("clr_after", data_w, 4);

    // async reset mid-transfer
    step(1, 1, 9, 0, 0, "ar0");
    #2 rst = 1'b1;
    #1;
    chk("ar_vld", vld_w, 0);
    chk("ar_data", data_w, 0);
    chk("ar_cnt", cnt_w, 0);
    chk("ar_ovf_s", ovf_s, 0);
    model_reset();
    @(negedge clk);
    check_outputs("ar_hold");
    rst = 1'b0;
    step(1, 0, 7, 1, 0, "ar1");
    chk("ar_after", data_w, 7);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 127)) - 64,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0,
           "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sint_delta_decoder.md
Name: sint_delta_decoder

Overview:
- Reconstructs absolute signed samples from a stream of signed differences; the receive-side inverse of the SInt subtract-based delta encoder.
- Each accepted delta is added to a running accumulator, and the result is emitted on a registered valid/ready output.
- Sits between a delta-coded link and downstream consumers of absolute SInt samples.
- A keyframe flag loads an absolute value so the decoder can resynchronise.

Parameters:
- WIDTH, 7, bit width of deltas, accumulator and output (two's complement SInt).
- SATURATE, 0, 0 = wrap on overflow; 1 = clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- INIT, 0, accumulator value after reset or clear (signed, must fit WIDTH).
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESET  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart of the stream state.
- in_valid  in  1  delta present.
- in_ready  out  1  decoder can accept this cycle.
- in_first  in  1  keyframe: in_delta is an absolute sample, not a difference.
- in_delta  in  WIDTH  signed delta, or absolute value when in_first=1.
- out_valid  out  1  out_data holds a reconstructed sample.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  reconstructed signed sample.
- overflow  out  1  sticky: some accumulation exceeded the signed range.
- sample_count  out  CNT_W  number of accepted inputs, wraps modulo 2^CNT_W.

Behaviour:
- Reset (ASYNCRESET=1, acts immediately, independent of CLK):
  - acc=INIT, out_valid=0, out_data=INIT, overflow=0, sample_count=0.
  - Everything is held while reset is asserted.
  - Reset mid-transfer discards the pending output with no handshake completion.
- Output register states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !clear && (!out_valid || out_ready), i.e. a pass-through pipeline with one cycle of latency.
  - There is no combinational path from in_valid or in_delta to the outputs.
- Accept occurs when in_valid && in_ready at a clock edge:
  - sum = sext(acc) + sext(in_delta), computed in WIDTH+1 bits.
  - ovf = (sum[WIDTH] != sum[WIDTH-1]).
  - With in_first=1: result = in_delta, ovf = 0.
  - Otherwise, SATURATE=0: result = sum[WIDTH-1:0].
  - Otherwise, SATURATE=1: on ovf, result = max positive if sum is positive, or min negative if sum is negative; no ovf means result = sum truncated.
  - acc=result, out_data=result, out_valid=1 (state FULL), overflow |= ovf, sample_count += 1 (wraps).
- Consume without accept (out_valid && out_ready, and no accept): out_valid=0 (state EMPTY). out_data holds its last value.
- Consume and accept in the same cycle: state stays FULL with the new result, giving back-to-back throughput of one sample per cycle.
- Stall (out_valid && !out_ready): out_data, out_valid and acc hold exactly; in_ready=0.
- clear=1 at an edge has priority over everything else:
  - acc=INIT, out_valid=0, overflow=0, sample_count=0.
  - No input is accepted that cycle, because in_ready is forced low.
  - out_data is left unchanged.
- in_valid with in_delta held stable is not required of the source. The decoder samples only on an accept.

Decomposition:
- Package sint_delta_pkg holds:
  - default WIDTH/CNT_W constants;
  - functions smax(WIDTH)=2^(WIDTH-1)-1 and smin(WIDTH)=-2^(WIDTH-1);
  - the enum for output state {EMPTY, FULL}.
- Sub-module sint_add_ovf: combinational WIDTH-bit signed add with a SATURATE parameter, outputs result and ovf.
  - It is reused by a future delta encoder's reconstruction check.
- The top level holds the accumulator, output register, counter and handshake logic.

Test Plan:
- Basic accumulation (WIDTH=7, SATURATE=0, out_ready=1): first=1 with 5, then deltas -3, 10 -> out_data 5, 2, 12 on consecutive cycles, each one cycle after accept; sample_count=3; overflow=0.
- Positive and negative wrap (SATURATE=0): acc=60, delta 10 -> out_data -58, overflow=1. Then first=1 with -60, followed by delta -10 -> out_data 58, and overflow stays 1.
- Saturation (SATURATE=1): acc=60, delta 10 -> 63, overflow=1. Then first=1 with -60, followed by delta -10 -> -64.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 and out_valid=1 -> in_ready=0, out_data stable, acc unchanged. Then release -> the next delta is accepted in the same cycle the held sample is consumed.
- clear together with in_valid=1 at acc=30: no accept, out_valid=0, sample_count=0, overflow=0. The next delta 4 -> out_data 4 (INIT=0).
- Async reset asserted mid-stream while out_valid=1 -> outputs go to reset values immediately, before the next CLK edge. After release, the first delta 7 -> out_data 7.
